mux_rr_stream: RTL and testbench
================================

# mux_rr_stream

Parametrised N-channel, W-bit stream multiplexer: the successor to the team's combinational 4:1 mux. Selects one of N valid/ready input channels per cycle, either by round-robin arbitration or by a fixed select (legacy mux mode), and registers the winner into a one-entry output stage. It sits between multiple producers and a single consumer wherever a shared datapath must be time-shared without dropping data.

## Interface
Parameters:
- N, 4, number of input channels (N ≥ 2)
- W, 8, data width per channel
- SW, clog2(N), select/index width (derived, not overridden)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- mode  input  1  0 = round-robin, 1 = fixed select
- sel  input  SW  channel index used when mode = 1
- in_valid  input  N  per-channel valid; bit i = channel i
- in_data  input  N*W  channel i occupies bits [i*W +: W]
- in_ready  output  N  per-channel ready, one-hot or zero
- out_valid  output  1  output register holds data
- out_data  output  W  registered data
- out_sel  output  SW  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready

## Operation
- Output stage has two states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
- can_load = EMPTY | (FULL & out_ready).
- Grant, combinational:
  - mode = 0: first channel with in_valid set, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - mode = 1: channel sel if in_valid[sel], else none. sel ≥ N grants none.
- in_ready[g] = can_load for granted g; all other bits 0. in_ready never depends on out_valid of the same channel.
- Transfer on input i: in_valid[i] & in_ready[i]. At the clock edge: out_data ← in_data[i], out_sel ← i, out_valid ← 1.
- FULL & out_ready with no transfer: out_valid ← 0; out_data and out_sel hold their values.
- FULL & ~out_ready: the register holds, and all in_ready are 0.
- Round-robin pointer ptr (SW bits):
  - On a transfer from channel g in mode 0, ptr ← (g+1) mod N. Wrap from N-1 to 0.
  - Otherwise ptr holds, including during mode 1.
- mode and sel may change on any cycle and take effect the same cycle. Data already in the output register is unaffected.
- Reset, asynchronous: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0, in_ready = 0 while rst is high. Reset mid-transfer discards the held word.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle while out_ready stays high, including a simultaneous pop and load in the FULL state.
- No combinational path from in_valid/in_data to out_*.
- Combinational paths exist from out_ready, mode, sel and in_valid to in_ready.
- The first edge after rst deasserts may accept data.

## Structure
- Package mux_pkg:
  - clog2 function
  - MODE_RR = 1'b0, MODE_FIXED = 1'b1
  - ST_EMPTY / ST_FULL encoding
- Sub-module rr_arbiter (N, SW): inputs req[N] and ptr; outputs gnt (one-hot) and gnt_idx, plus any flag. Purely combinational.
- Top holds ptr, the output register, the fixed-mode override and the in_ready gating.

## Test plan
- Reset: assert rst mid-stream with out_valid = 1 → out_valid, out_data, out_sel and in_ready all 0 immediately. First grant after release goes to channel 0.
- Round-robin fairness: N = 4, all in_valid = 1, out_ready = 1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3. One word per cycle.
- Sparse requests with wrap: ptr = 3, only channels 1 and 3 valid → grant 3, then 1 (wrap through 0), then 3.
- Backpressure: out_ready = 0 with out_valid = 1 for 5 cycles → out_data stable and in_ready = 0. Raising out_ready gives a simultaneous pop and load next edge.
- Fixed mode: mode = 1, sel = 2, in_valid = 4'b1111, in_data[2] = 8'hA5 → only in_ready[2] = 1, out_data = 8'hA5, out_sel = 2, ptr unchanged. sel = 2 with in_valid[2] = 0 → no transfer.
- Parameter sweep: N = 3 and W = 16 → wrap from 2 to 0, and sel = 3 grants none.

Source files
------------

// File: rtl/mux_pkg.sv
// ============================================================================
// Module   : mux_pkg
// Brief    : Shared constants and helpers for the round-robin stream mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; search starts at ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx,
    output logic          any
);

    // Outer loop walks priority order ptr, ptr+1, ...; first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!any && req[j] && (j == ((int'(ptr) + k) % N))) begin
                    any     = 1'b1;
                    gnt[j]  = 1'b1;
                    gnt_idx = SW'(j);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_rr_stream.sv
// ============================================================================
// Module   : mux_rr_stream
// Brief    : N-channel valid/ready mux, round-robin or fixed select, with a
//            one-entry registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_stream
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    logic [0:0]    r_state_q, w_state_d;
    logic [W-1:0]  r_data_q,  w_data_d;
    logic [SW-1:0] r_sel_q,   w_sel_d;
    logic [SW-1:0] r_ptr_q,   w_ptr_d;

    logic [N-1:0]  w_rr_gnt;
    logic [SW-1:0] w_rr_idx;
    logic          w_rr_any;
    logic [N-1:0]  w_gnt;
    logic [SW-1:0] w_gnt_idx;
    logic          w_gnt_any;
    logic          w_can_load;
    logic          w_xfer;
    logic [W-1:0]  w_win_data;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (r_ptr_q),
        .gnt     (w_rr_gnt),
        .gnt_idx (w_rr_idx),
        .any     (w_rr_any)
    );

    // Fixed mode overrides the arbiter; an out-of-range sel matches nothing.
    always_comb begin
        w_gnt     = w_rr_gnt;
        w_gnt_idx = w_rr_idx;
        w_gnt_any = w_rr_any;
        if (mode == MODE_FIXED) begin
            w_gnt     = '0;
            w_gnt_idx = sel;
            w_gnt_any = 1'b0;
            for (int i = 0; i < N; i++) begin
                if ((sel == SW'(i)) && in_valid[i]) begin
                    w_gnt[i]  = 1'b1;
                    w_gnt_any = 1'b1;
                end
            end
        end
    end

    assign w_can_load = !rst && ((r_state_q == ST_EMPTY) || out_ready);
    assign in_ready   = w_can_load ? w_gnt : '0;
    assign w_xfer     = w_can_load && w_gnt_any;

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_win_data = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_data_d  = r_data_q;
        w_sel_d   = r_sel_q;
        w_ptr_d   = r_ptr_q;
        if (w_xfer) begin
            w_state_d = ST_FULL;
            w_data_d  = w_win_data;
            w_sel_d   = w_gnt_idx;
            if (mode == MODE_RR) begin
                w_ptr_d = (w_gnt_idx == SW'(N - 1)) ? '0 : (w_gnt_idx + SW'(1));
            end
        end else if ((r_state_q == ST_FULL) && out_ready) begin
            w_state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= ST_EMPTY;
            r_data_q  <= '0;
            r_sel_q   <= '0;
            r_ptr_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_data_q  <= w_data_d;
            r_sel_q   <= w_sel_d;
            r_ptr_q   <= w_ptr_d;
        end
    end

    assign out_valid = (r_state_q == ST_FULL);
    assign out_data  = r_data_q;
    assign out_sel   = r_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_stream.sv
// ============================================================================
// Module   : tb_mux_rr_stream
// Brief    : Scoreboard bench for mux_rr_stream (N=4/W=8 and N=3/W=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_stream;

    logic clk;
    logic rst;

    logic        a_mode;
    logic [1:0]  a_sel;
    logic [3:0]  a_in_valid;
    logic [31:0] a_in_data;
    logic [3:0]  a_in_ready;
    logic        a_out_valid;
    logic [7:0]  a_out_data;
    logic [1:0]  a_out_sel;
    logic        a_out_ready;

    logic        b_mode;
    logic [1:0]  b_sel;
    logic [2:0]  b_in_valid;
    logic [47:0] b_in_data;
    logic [2:0]  b_in_ready;
    logic        b_out_valid;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_sel;
    logic        b_out_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [9:0]  qa[$];
    logic [17:0] qb[$];

    mux_rr_stream #(.N(4), .W(8)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .mode      (a_mode),
        .sel       (a_sel),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_sel   (a_out_sel),
        .out_ready (a_out_ready)
    );

    mux_rr_stream #(.N(3), .W(16)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .mode      (b_mode),
        .sel       (b_sel),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel),
        .out_ready (b_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pa(input int k);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(k * 4 + i);
        return r;
    endfunction

    function automatic logic [47:0] pb(input int k);
        logic [47:0] r;
        for (int i = 0; i < 3; i++) r[i*16 +: 16] = 16'(16'hB000 + k * 3 + i);
        return r;
    endfunction

    // One cycle on DUT A: check in_ready mid-cycle and queue the granted word.
    task automatic cyc_a(input string name, input logic [3:0] exp_rdy, input logic [31:0] data);
        a_in_data = data;
        @(negedge clk);
        chk(name, 64'(a_in_ready), 64'(exp_rdy));
        for (int i = 0; i < 4; i++) if (exp_rdy[i]) qa.push_back({2'(i), data[i*8 +: 8]});
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input string name, input logic [2:0] exp_rdy, input logic [47:0] data);
        b_in_data = data;
        @(negedge clk);
        chk(name, 64'(b_in_ready), 64'(exp_rdy));
        for (int i = 0; i < 3; i++) if (exp_rdy[i]) qb.push_back({2'(i), data[i*16 +: 16]});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL a_word: got unexpected %0h/%0h, queue empty", a_out_sel, a_out_data);
            end else begin
                chk("a_word", 64'({a_out_sel, a_out_data}), 64'(qa.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b_word: got unexpected %0h/%0h, queue empty", b_out_sel, b_out_data);
            end else begin
                chk("b_word", 64'({b_out_sel, b_out_data}), 64'(qb.pop_front()));
            end
        end
    end

    initial begin
        logic [31:0] tmp;
        logic [7:0]  held;

        rst = 1'b1;
        a_mode = 1'b0; a_sel = 2'd0; a_in_valid = 4'hF; a_in_data = pa(0); a_out_ready = 1'b1;
        b_mode = 1'b0; b_sel = 2'd0; b_in_valid = 3'b000; b_in_data = pb(0); b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(a_out_valid), 64'(0));
        chk("reset_in_ready",  64'(a_in_ready),  64'(0));
        rst = 1'b0;

        for (int k = 0; k < 8; k++) cyc_a("rr_fair", 4'(1 << (k % 4)), pa(k + 1));
        a_in_valid = 4'h0;
        cyc_a("idle1", 4'b0000, pa(9));

        a_in_valid = 4'b0100;
        cyc_a("sparse_set_ptr3", 4'b0100, pa(10));
        a_in_valid = 4'b1010;
        cyc_a("sparse_grant3",  4'b1000, pa(11));
        cyc_a("sparse_wrap1",   4'b0010, pa(12));
        cyc_a("sparse_grant3b", 4'b1000, pa(13));
        a_in_valid = 4'h0;
        cyc_a("idle2", 4'b0000, pa(14));

        a_in_valid = 4'b0001;
        tmp = pa(20);
        held = tmp[7:0];
        cyc_a("bp_load", 4'b0001, tmp);
        a_out_ready = 1'b0;
        a_in_valid  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            cyc_a("bp_stall_ready", 4'b0000, pa(21 + k));
            chk("bp_hold_valid", 64'(a_out_valid), 64'(1));
            chk("bp_hold_data",  64'(a_out_data),  64'(held));
        end
        a_out_ready = 1'b1;
        cyc_a("bp_pop_and_load", 4'b0010, pa(30));
        a_in_valid = 4'b1000;
        cyc_a("rr_to_ch3", 4'b1000, pa(31));

        a_mode = 1'b1; a_sel = 2'd2; a_in_valid = 4'hF;
        tmp = pa(32);
        tmp[23:16] = 8'hA5;
        cyc_a("fixed_sel2", 4'b0100, tmp);
        a_in_valid = 4'b1011;
        cyc_a("fixed_sel2_not_valid", 4'b0000, pa(33));
        a_mode = 1'b0; a_in_valid = 4'hF;
        cyc_a("ptr_kept_in_fixed", 4'b0001, pa(34));

        a_out_ready = 1'b0;
        cyc_a("pre_reset_stall", 4'b0000, pa(35));
        chk("pre_reset_full", 64'(a_out_valid), 64'(1));
        #2;
        rst = 1'b1;
        a_out_ready = 1'b1;
        #1;
        qa.delete();
        chk("async_reset_valid", 64'(a_out_valid), 64'(0));
        chk("async_reset_data",  64'(a_out_data),  64'(0));
        chk("async_reset_sel",   64'(a_out_sel),   64'(0));
        chk("async_reset_ready", 64'(a_in_ready),  64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc_a("post_reset_ch0", 4'b0001, pa(36));
        a_in_valid = 4'h0;
        cyc_a("drain_a", 4'b0000, pa(37));

        b_in_valid = 3'b111;
        for (int k = 0; k < 4; k++) cyc_b("b_rr_wrap", 3'(1 << (k % 3)), pb(k + 1));
        b_mode = 1'b1; b_sel = 2'd3;
        cyc_b("b_sel3_none", 3'b000, pb(5));
        b_sel = 2'd1;
        cyc_b("b_fixed_sel1", 3'b010, pb(6));
        b_mode = 1'b0; b_in_valid = 3'b000;
        cyc_b("drain_b", 3'b000, pb(7));
        cyc_b("idle_b",  3'b000, pb(8));

        @(negedge clk);
        chk("a_queue_empty", 64'(qa.size()), 64'(0));
        chk("b_queue_empty", 64'(qb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
